// File: rtl/seq_decode_unit_pkg.sv
// Shared encodings for the LC-3 style sequencer: states, mux selects,
// ALU functions, opcodes and the wait-counter width.
package SLC3_2;

    typedef logic [4:0] state_t;

    localparam state_t ST_HALTED = 5'd0;
    localparam state_t ST_F18    = 5'd1;
    localparam state_t ST_F33    = 5'd2;
    localparam state_t ST_F35    = 5'd3;
    localparam state_t ST_PIR1   = 5'd4;
    localparam state_t ST_PIR2   = 5'd5;
    localparam state_t ST_D32    = 5'd6;
    localparam state_t ST_S01    = 5'd7;
    localparam state_t ST_S05    = 5'd8;
    localparam state_t ST_S09    = 5'd9;
    localparam state_t ST_S00    = 5'd10;
    localparam state_t ST_S22    = 5'd11;
    localparam state_t ST_S12    = 5'd12;
    localparam state_t ST_S04    = 5'd13;
    localparam state_t ST_S20    = 5'd14;
    localparam state_t ST_S21    = 5'd15;
    localparam state_t ST_S06    = 5'd16;
    localparam state_t ST_S25    = 5'd17;
    localparam state_t ST_S27    = 5'd18;
    localparam state_t ST_S07    = 5'd19;
    localparam state_t ST_S23    = 5'd20;
    localparam state_t ST_S16    = 5'd21;
    localparam state_t ST_P13A   = 5'd22;
    localparam state_t ST_P13B   = 5'd23;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] A2_ZERO  = 2'b00;
    localparam logic [1:0] A2_OFF6  = 2'b01;
    localparam logic [1:0] A2_OFF9  = 2'b10;
    localparam logic [1:0] A2_OFF11 = 2'b11;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam int WAIT_W = $clog2(8) + 1;

    // A wait of n cycles counts n-1 down to zero
    function automatic logic [WAIT_W-1:0] wait_init(input int n);
        return WAIT_W'(n - 1);
    endfunction

endpackage

// File: rtl/seq_decode_unit_wait_timer.sv
// Down-counter pacing SRAM read/write waits; saturates at zero.
module wait_timer
    import SLC3_2::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              count,
    output logic              done
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/seq_decode_unit.sv
// Microsequencer for a small LC-3 subset: fetch, decode, execute,
// with SRAM wait pacing and front-panel pause handshakes.
module seq_decode_unit
    import SLC3_2::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int WR_WAIT  = 2,
    parameter int PAUSE_IR = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Halted_o
);

    localparam logic [WAIT_W-1:0] RD_INIT = wait_init(MEM_WAIT);
    localparam logic [WAIT_W-1:0] WR_INIT = wait_init(WR_WAIT);

    state_t            state;
    state_t            state_nxt;
    logic              tmr_load;
    logic              tmr_count;
    logic              tmr_done;
    logic [WAIT_W-1:0] tmr_val;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= ST_HALTED;
        end else begin
            state <= state_nxt;
        end
    end

    wait_timer u_wait (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    assign Mem_CE   = 1'b0;
    assign Mem_UB   = 1'b0;
    assign Mem_LB   = 1'b0;
    assign Halted_o = (state == ST_HALTED);

    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_count  = 1'b0;
        tmr_val    = '0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = A2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        unique case (state)
            ST_HALTED: begin
                if (Run) state_nxt = ST_F18;
            end
            ST_F18: begin
                GatePC    = 1'b1;
                LD_MAR    = 1'b1;
                LD_PC     = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = RD_INIT;
                state_nxt = ST_F33;
            end
            ST_F33, ST_S25: begin
                Mem_OE    = 1'b0;
                tmr_count = 1'b1;
                if (tmr_done) begin
                    LD_MDR    = 1'b1;
                    state_nxt = (state == ST_F33) ? ST_F35 : ST_S27;
                end
            end
            ST_F35: begin
                GateMDR   = 1'b1;
                LD_IR     = 1'b1;
                state_nxt = (PAUSE_IR != 0) ? ST_PIR1 : ST_D32;
            end
            ST_PIR1: begin
                if (Continue) state_nxt = ST_PIR2;
            end
            ST_PIR2: begin
                if (!Continue) state_nxt = ST_D32;
            end
            ST_D32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   state_nxt = ST_S01;
                    OP_AND:   state_nxt = ST_S05;
                    OP_NOT:   state_nxt = ST_S09;
                    OP_BR:    state_nxt = ST_S00;
                    OP_JMP:   state_nxt = ST_S12;
                    OP_JSR:   state_nxt = ST_S04;
                    OP_LDR:   state_nxt = ST_S06;
                    OP_STR:   state_nxt = ST_S07;
                    OP_PAUSE: state_nxt = ST_P13A;
                    default:  state_nxt = ST_F18;
                endcase
            end
            ST_S01, ST_S05, ST_S09: begin
                SR1MUX    = 1'b1;
                GateALU   = 1'b1;
                LD_REG    = 1'b1;
                LD_CC     = 1'b1;
                SR2MUX    = (state == ST_S09) ? 1'b0 : IR_5;
                ALUK      = (state == ST_S01) ? ALUK_ADD :
                            (state == ST_S05) ? ALUK_AND : ALUK_NOT;
                state_nxt = ST_F18;
            end
            ST_S00: begin
                state_nxt = BEN ? ST_S22 : ST_F18;
            end
            ST_S22: begin
                ADDR2MUX  = A2_OFF9;
                PCMUX     = PCMUX_ADDER;
                LD_PC     = 1'b1;
                state_nxt = ST_F18;
            end
            ST_S12, ST_S20: begin
                SR1MUX    = 1'b1;
                ADDR1MUX  = 1'b1;
                PCMUX     = PCMUX_ADDER;
                LD_PC     = 1'b1;
                state_nxt = ST_F18;
            end
            ST_S04: begin
                GatePC    = 1'b1;
                DRMUX     = 1'b1;
                LD_REG    = 1'b1;
                state_nxt = IR_11 ? ST_S21 : ST_S20;
            end
            ST_S21: begin
                ADDR2MUX  = A2_OFF11;
                PCMUX     = PCMUX_ADDER;
                LD_PC     = 1'b1;
                state_nxt = ST_F18;
            end
            ST_S06, ST_S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = A2_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                tmr_load   = 1'b1;
                tmr_val    = (state == ST_S06) ? RD_INIT : '0;
                state_nxt  = (state == ST_S06) ? ST_S25 : ST_S23;
            end
            ST_S27: begin
                GateMDR   = 1'b1;
                LD_REG    = 1'b1;
                LD_CC     = 1'b1;
                state_nxt = ST_F18;
            end
            ST_S23: begin
                ALUK      = ALUK_PASSA;
                GateALU   = 1'b1;
                LD_MDR    = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = WR_INIT;
                state_nxt = ST_S16;
            end
            ST_S16: begin
                Mem_WE    = 1'b0;
                tmr_count = 1'b1;
                if (tmr_done) state_nxt = ST_F18;
            end
            ST_P13A: begin
                LD_LED = 1'b1;
                if (Continue) state_nxt = ST_P13B;
            end
            ST_P13B: begin
                if (!Continue) state_nxt = ST_F18;
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

endmodule

// File: tb/tb_seq_decode_unit.sv
// Cycle-by-cycle scoreboard bench for seq_decode_unit with
// MEM_WAIT=3, WR_WAIT=4 and the IR pause enabled.
module tb_seq_decode_unit;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = '0;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN;
    logic       LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic       Halted_o;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    seq_decode_unit #(
        .MEM_WAIT (3),
        .WR_WAIT  (4),
        .PAUSE_IR (1)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Run        (Run),
        .Continue   (Continue),
        .Opcode     (Opcode),
        .IR_5       (IR_5),
        .IR_11      (IR_11),
        .BEN        (BEN),
        .LD_MAR     (LD_MAR),
        .LD_MDR     (LD_MDR),
        .LD_IR      (LD_IR),
        .LD_BEN     (LD_BEN),
        .LD_CC      (LD_CC),
        .LD_REG     (LD_REG),
        .LD_PC      (LD_PC),
        .LD_LED     (LD_LED),
        .GatePC     (GatePC),
        .GateMDR    (GateMDR),
        .GateALU    (GateALU),
        .GateMARMUX (GateMARMUX),
        .PCMUX      (PCMUX),
        .DRMUX      (DRMUX),
        .SR1MUX     (SR1MUX),
        .SR2MUX     (SR2MUX),
        .ADDR1MUX   (ADDR1MUX),
        .ADDR2MUX   (ADDR2MUX),
        .ALUK       (ALUK),
        .Mem_CE     (Mem_CE),
        .Mem_UB     (Mem_UB),
        .Mem_LB     (Mem_LB),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE),
        .Halted_o   (Halted_o)
    );

    // Control word: one bit per control, tied-off CE/UB/LB folded in
    // at the top so a stuck tie-off shows up too.
    logic [27:0] obs;
    assign obs = {Mem_CE, Mem_UB, Mem_LB, Halted_o,
                  LD_MAR, LD_MDR, LD_IR, LD_BEN,
                  LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX,
                  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
                  ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    localparam logic [27:0] ONE   = 28'd1;
    localparam logic [27:0] IDLE  = 28'b11;
    localparam logic [27:0] OE_L  = ONE << 1;
    localparam logic [27:0] WE_L  = ONE;
    localparam logic [27:0] HALT  = ONE << 24;
    localparam logic [27:0] LMAR  = ONE << 23;
    localparam logic [27:0] LMDR  = ONE << 22;
    localparam logic [27:0] LIR   = ONE << 21;
    localparam logic [27:0] LBEN  = ONE << 20;
    localparam logic [27:0] LCC   = ONE << 19;
    localparam logic [27:0] LREG  = ONE << 18;
    localparam logic [27:0] LPC   = ONE << 17;
    localparam logic [27:0] LLED  = ONE << 16;
    localparam logic [27:0] GPC   = ONE << 15;
    localparam logic [27:0] GMDR  = ONE << 14;
    localparam logic [27:0] GALU  = ONE << 13;
    localparam logic [27:0] GMARM = ONE << 12;
    localparam logic [27:0] PC_AD = 28'd2 << 10;
    localparam logic [27:0] DR7   = ONE << 9;
    localparam logic [27:0] SR1   = ONE << 8;
    localparam logic [27:0] SR2   = ONE << 7;
    localparam logic [27:0] A1SR  = ONE << 6;
    localparam logic [27:0] A2_6  = 28'd1 << 4;
    localparam logic [27:0] A2_9  = 28'd2 << 4;
    localparam logic [27:0] A2_11 = 28'd3 << 4;
    localparam logic [27:0] K_AND = 28'd1 << 2;
    localparam logic [27:0] K_NOT = 28'd2 << 2;
    localparam logic [27:0] K_PSA = 28'd3 << 2;

    localparam logic [27:0] W_HALT = IDLE | HALT;
    localparam logic [27:0] W_RD   = IDLE ^ OE_L;
    localparam logic [27:0] W_WR   = IDLE ^ WE_L;
    localparam logic [27:0] W_JMP  = IDLE | SR1 | A1SR | PC_AD | LPC;
    localparam logic [27:0] W_EA   = IDLE | SR1 | A1SR | A2_6
                                   | GMARM | LMAR;

    typedef struct {
        string       tag;
        logic [27:0] exp;
        logic        cont;
    } sb_t;

    sb_t sb[$];

    task automatic chk(input string tag, input logic [27:0] got,
                       input logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [27:0] exp,
                        input logic cont);
        sb_t e;
        e.tag  = tag;
        e.exp  = exp;
        e.cont = cont;
        sb.push_back(e);
    endtask

    task automatic set_ir(input logic [15:0] ir, input logic ben);
        Opcode = ir[15:12];
        IR_5   = ir[5];
        IR_11  = ir[11];
        BEN    = ben;
    endtask

    // early: Continue already high on entry to PIR1
    task automatic push_fetch(input bit early);
        push("F18", IDLE | GPC | LMAR | LPC, 1'b0);
        push("F33a", W_RD, 1'b0);
        push("F33b", W_RD, 1'b0);
        push("F33c", W_RD | LMDR, 1'b0);
        push("F35", IDLE | GMDR | LIR, early);
        push("PIR1", IDLE, 1'b1);
        if (early) push("PIR2h", IDLE, 1'b1);
        push("PIR2", IDLE, 1'b0);
        push("D32", IDLE | LBEN, 1'b0);
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
            if (Mem_OE === 1'b0 && Mem_WE === 1'b0)
                chk("oe_we_overlap", obs, obs ^ WE_L);
            Continue = e.cont;
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        Run      = 1'b1;
        Continue = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            chk("rst_halt", obs, W_HALT);
        end
        Reset_n = 1'b1;

        set_ir(16'h1261, 1'b0);
        push_fetch(1'b0);
        push("S01", IDLE | SR1 | SR2 | GALU | LREG | LCC, 1'b0);
        drain();
        Run = 1'b0;

        set_ir(16'h5042, 1'b0);
        push_fetch(1'b1);
        push("S05", IDLE | SR1 | K_AND | GALU | LREG | LCC, 1'b0);
        drain();

        set_ir(16'h903F, 1'b0);
        push_fetch(1'b0);
        push("S09", IDLE | SR1 | K_NOT | GALU | LREG | LCC, 1'b0);
        drain();

        set_ir(16'h0A05, 1'b1);
        push_fetch(1'b0);
        push("S00t", IDLE, 1'b0);
        push("S22", IDLE | A2_9 | PC_AD | LPC, 1'b0);
        drain();

        set_ir(16'h0A05, 1'b0);
        push_fetch(1'b0);
        push("S00n", IDLE, 1'b0);
        drain();

        set_ir(16'h4802, 1'b0);
        push_fetch(1'b0);
        push("S04", IDLE | GPC | DR7 | LREG, 1'b0);
        push("S21", IDLE | A2_11 | PC_AD | LPC, 1'b0);
        drain();

        set_ir(16'h4080, 1'b0);
        push_fetch(1'b0);
        push("S04r", IDLE | GPC | DR7 | LREG, 1'b0);
        push("S20", W_JMP, 1'b0);
        drain();

        set_ir(16'hC1C0, 1'b0);
        push_fetch(1'b0);
        push("S12", W_JMP, 1'b0);
        drain();

        set_ir(16'h6042, 1'b0);
        push_fetch(1'b0);
        push("S06", W_EA, 1'b0);
        push("S25a", W_RD, 1'b0);
        push("S25b", W_RD, 1'b0);
        push("S25c", W_RD | LMDR, 1'b0);
        push("S27", IDLE | GMDR | LREG | LCC, 1'b0);
        drain();

        set_ir(16'h7042, 1'b0);
        push_fetch(1'b0);
        push("S07", W_EA, 1'b0);
        push("S23", IDLE | K_PSA | GALU | LMDR, 1'b0);
        for (int i = 0; i < 4; i++) push("S16", W_WR, 1'b0);
        drain();

        set_ir(16'hD0FF, 1'b0);
        push_fetch(1'b0);
        push("P13A", IDLE | LLED, 1'b1);
        push("P13B", IDLE, 1'b0);
        drain();

        set_ir(16'h8000, 1'b0);
        push_fetch(1'b0);
        drain();

        // Reset landing in the middle of a read wait
        push("F18w", IDLE | GPC | LMAR | LPC, 1'b0);
        push("F33w", W_RD, 1'b0);
        drain();
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        chk("rst_midwait", obs, W_HALT);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("halt_norun", obs, W_HALT);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_decode_unit.md
SEQ_DECODE_UNIT -- requirements
Module: seq_decode_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, SRAM read wait cycles (1..8) before MDR load.
REQ-002 SHALL have parameter WR_WAIT, default 2, SRAM write-enable cycles (1..8).
REQ-003 SHALL have parameter PAUSE_IR, default 1, nonzero inserts IR-display pause after every fetch.
REQ-004 Clk  in  1  single clock; all state changes on posedge.
REQ-005 Reset_n  in  1  synchronous, active-low reset.
REQ-006 Run, Continue  in  1 each  level-sensitive front-panel controls.
REQ-007 Opcode  in  4  IR[15:12]; IR_5, IR_11, BEN  in  1 each.
REQ-008 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads.
REQ-009 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle.
REQ-010 PCMUX  out  2  00 PC+1, 01 bus, 10 address adder.
REQ-011 DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1 each  DR 0=IR[11:9]/1=R7; SR1 0=IR[11:9]/1=IR[8:6]; SR2 0=reg/1=imm5; ADDR1 0=PC/1=SR1.
REQ-012 ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11; ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA.
REQ-013 Mem_CE, Mem_UB, Mem_LB  out  1 each  tied 0; Mem_OE, Mem_WE  out  1 each  active-low.
REQ-014 Halted_o  out  1  high in HALTED state only.

Function
REQ-015 States: HALTED, F18, F33 (read wait), F35, PIR1, PIR2, D32, S01, S05, S09, S00, S22, S12, S04, S20, S21, S06, S25 (read wait), S27, S07, S23, S16 (write wait), P13A, P13B.
REQ-016 Default every cycle: all loads/gates/muxes 0, Mem_OE=1, Mem_WE=1, next state = current.
REQ-017 HALTED -> F18 when Run=1; F18: GatePC, LD_MAR, LD_PC, PCMUX=00.
REQ-018 F33 and S25: Mem_OE=0 for exactly MEM_WAIT cycles via down-counter; LD_MDR=1 on final cycle only; then F35/S27.
REQ-019 F35: GateMDR, LD_IR; next PIR1 if PAUSE_IR else D32.
REQ-020 PIR1 holds until Continue=1, then PIR2; PIR2 holds until Continue=0, then D32.
REQ-021 D32: LD_BEN; dispatch 0001 S01, 0101 S05, 1001 S09, 0000 S00, 1100 S12, 0100 S04, 0110 S06, 0111 S07, 1101 P13A; other opcodes -> F18.
REQ-022 S01/S05: SR1MUX=1, SR2MUX=IR_5, ALUK 00/01, GateALU, LD_REG, LD_CC -> F18; S09 same with ALUK=10, SR2MUX=0.
REQ-023 S00 -> S22 if BEN else F18; S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> F18.
REQ-024 S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> F18.
REQ-025 S04: GatePC, DRMUX=1, LD_REG (R7<-PC) -> S21 if IR_11 else S20; S21: ADDR2MUX=11, ADDR1MUX=0, PCMUX=10, LD_PC; S20: as S12; both -> F18.
REQ-026 S06/S07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> S25/S23.
REQ-027 S27: GateMDR, LD_REG, LD_CC, DRMUX=0 -> F18.
REQ-028 S23: SR1MUX=0, ALUK=11, GateALU, LD_MDR -> S16; S16: Mem_WE=0 for WR_WAIT cycles, Mem_OE=1 -> F18.
REQ-029 P13A: LD_LED; holds until Continue=1 -> P13B; P13B holds until Continue=0 -> F18.
REQ-030 Wait counter width $clog2(8)+1; loaded with wait-1 on entry to wait state; never wraps.
REQ-031 Run deasserted mid-instruction SHALL NOT abort; only Reset_n returns to HALTED.
REQ-032 Continue held high entering PIR1/P13A advances after one cycle; P13B/PIR2 then wait for release (no double-step).

Reset
REQ-033 Reset_n=0 at posedge: state HALTED, counter 0; next cycle outputs equal REQ-016 defaults, Halted_o=1.
REQ-034 Reset mid-wait (F33/S16) SHALL deassert Mem_OE/Mem_WE on the following cycle.

Structure
REQ-035 State enum, ALUK/PCMUX/ADDR2MUX encodings and opcode constants SHALL live in package SLC3_2.
REQ-036 Wait counter SHALL be sub-module wait_timer (load, count, done).

Verification
REQ-037 Reset_n=0, Run=1 -> HALTED held; release -> F18 next cycle, GatePC=LD_MAR=LD_PC=1.
REQ-038 MEM_WAIT=3, fetch ADD x1261 -> Mem_OE=0 three cycles, LD_MDR on third, S01 with SR2MUX=1.
REQ-039 BR x0A05 with BEN=1 -> S22, PCMUX=10, ADDR2MUX=10; BEN=0 -> F18 after S00.
REQ-040 JSR x4802 -> S04 DRMUX=1 LD_REG, then S21 ADDR2MUX=11; JSRR x4080 -> S20.
REQ-041 STR with WR_WAIT=4 -> Mem_WE=0 exactly 4 cycles, never concurrent with Mem_OE=0.
REQ-042 PAUSE xD0FF, Continue pulse 1 cycle -> LD_LED once, P13A->P13B->F18; unknown opcode x8000 -> F18.
